// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: scalar widths, per-stage
// write-control encoding and the sequencer state set.
package hazard_ctrl_pkg;

  typedef logic [1:0]  u2;
  typedef logic [4:0]  u5;
  typedef logic [63:0] u64;

  typedef u2 stage_ctrl_t;

  localparam stage_ctrl_t CTRL_ADVANCE = 2'b00;
  localparam stage_ctrl_t CTRL_FLUSH   = 2'b01;
  localparam stage_ctrl_t CTRL_HOLD    = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MDU   = 2'd1,
    RPEND = 2'd2
  } hazard_state_t;

  // Write controls for all five stage registers, F first.
  typedef struct packed {
    stage_ctrl_t f;
    stage_ctrl_t d;
    stage_ctrl_t e;
    stage_ctrl_t m;
    stage_ctrl_t w;
  } stage_ctrl_vec_t;

  function automatic stage_ctrl_vec_t ctrl_all(input stage_ctrl_t c);
    stage_ctrl_vec_t v;
    v.f = c;
    v.d = c;
    v.e = c;
    v.m = c;
    v.w = c;
    return v;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// Down-counter tracking how long a multi-cycle MDU op still occupies E.
module mdu_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             cnt_zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional per-rule stall counters are built when STALL_PERF_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned PERF_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        d_stall,
  input  u5           ra1D,
  input  u5           ra2D,
  input  u5           dstE,
  input  logic        memreadE,
  input  logic        mdu_startE,
  input  logic        redirectE,
  input  u64          redirect_pcE,
  output stage_ctrl_t FWrite,
  output stage_ctrl_t DWrite,
  output stage_ctrl_t EWrite,
  output stage_ctrl_t MWrite,
  output stage_ctrl_t WWrite,
  output logic        pc_redirect,
  output u64          pc_target,
  output logic        mdu_busy
`ifdef STALL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_i,
  output logic [PERF_W-1:0] stall_cnt_d,
  output logic [PERF_W-1:0] stall_cnt_mdu,
  output logic [PERF_W-1:0] stall_cnt_lu
`endif
);

  localparam int unsigned CNT_W = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;

  hazard_state_t   state_q, state_d;
  u64              pend_pc_q, pend_pc_d;
  stage_ctrl_vec_t ctrl;
  logic            cnt_zero, mdu_load, mdu_dec;
  logic            load_use, mdu_hold, redir_ok;

  mdu_timer #(.CNT_W(CNT_W)) u_mdu_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (mdu_load),
    .load_val (CNT_W'(MDU_CYCLES - 1)),
    .dec_en   (mdu_dec),
    .cnt_zero (cnt_zero)
  );

  // Hazard detection, redirect handling, next state and stage controls.
  always_comb begin
    load_use    = memreadE && (dstE != '0) && ((dstE == ra1D) || (dstE == ra2D));
    mdu_hold    = (state_q == MDU) && !cnt_zero;
    // A redirect is only acted on when E is not frozen by rules 1/2;
    // otherwise E re-presents it next cycle.
    redir_ok    = !d_stall && !mdu_hold;
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    pc_redirect = 1'b0;
    pc_target   = pend_pc_q;
    mdu_load    = (state_q == IDLE) && mdu_startE;
    mdu_dec     = (state_q == MDU) && !d_stall;
    ctrl        = ctrl_all(CTRL_ADVANCE);

    // MDU expiry waits for d_stall release.
    if ((state_q == MDU) && cnt_zero && !d_stall) begin
      state_d = IDLE;
    end

    if (redir_ok) begin
      if (redirectE) begin
        if (!i_stall) begin
          pc_redirect = 1'b1;
          pc_target   = redirect_pcE;
          state_d     = IDLE;
        end else begin
          pend_pc_d = redirect_pcE;
          state_d   = RPEND;
        end
      end else if ((state_q == RPEND) && !i_stall) begin
        pc_redirect = 1'b1;
        pc_target   = pend_pc_q;
        state_d     = IDLE;
      end
    end

    if (mdu_load) begin
      state_d = MDU;
    end

    if (d_stall) begin
      ctrl   = ctrl_all(CTRL_HOLD);
      ctrl.w = CTRL_FLUSH;
    end else if (mdu_hold) begin
      ctrl   = ctrl_all(CTRL_HOLD);
      ctrl.m = CTRL_FLUSH;
      ctrl.w = CTRL_ADVANCE;
    end else if (load_use) begin
      ctrl.f = CTRL_HOLD;
      ctrl.d = CTRL_HOLD;
      ctrl.e = CTRL_FLUSH;
    end else if (redirectE || (state_q == RPEND)) begin
      ctrl.f = i_stall ? CTRL_HOLD : CTRL_ADVANCE;
      ctrl.d = CTRL_FLUSH;
      ctrl.e = redirectE ? CTRL_FLUSH : CTRL_ADVANCE;
    end else if (i_stall) begin
      ctrl.f = CTRL_HOLD;
      ctrl.d = CTRL_FLUSH;
    end

    // Reset flushes every stage and masks all stale state from the outputs.
    if (reset) begin
      ctrl        = ctrl_all(CTRL_FLUSH);
      pc_redirect = 1'b0;
      pc_target   = '0;
      state_d     = IDLE;
      pend_pc_d   = '0;
      mdu_load    = 1'b0;
    end
  end

  // Sequencer state and latched redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign FWrite   = ctrl.f;
  assign DWrite   = ctrl.d;
  assign EWrite   = ctrl.e;
  assign MWrite   = ctrl.m;
  assign WWrite   = ctrl.w;
  assign mdu_busy = !reset && (state_q == MDU);

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] cnt_i_q, cnt_i_d, cnt_d_q, cnt_d_d;
  logic [PERF_W-1:0] cnt_m_q, cnt_m_d, cnt_l_q, cnt_l_d;

  // One counter steps per cycle, chosen by the winning stall rule.
  always_comb begin
    cnt_i_d = cnt_i_q;
    cnt_d_d = cnt_d_q;
    cnt_m_d = cnt_m_q;
    cnt_l_d = cnt_l_q;
    if (d_stall) begin
      cnt_d_d = cnt_d_q + 1'b1;
    end else if (mdu_hold) begin
      cnt_m_d = cnt_m_q + 1'b1;
    end else if (load_use) begin
      cnt_l_d = cnt_l_q + 1'b1;
    end else if (!(redirectE || (state_q == RPEND)) && i_stall) begin
      cnt_i_d = cnt_i_q + 1'b1;
    end
  end

  // Stall counter registers, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_i_q <= '0;
      cnt_d_q <= '0;
      cnt_m_q <= '0;
      cnt_l_q <= '0;
    end else begin
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
      cnt_m_q <= cnt_m_d;
      cnt_l_q <= cnt_l_d;
    end
  end

  assign stall_cnt_i   = cnt_i_q;
  assign stall_cnt_d   = cnt_d_q;
  assign stall_cnt_mdu = cnt_m_q;
  assign stall_cnt_lu  = cnt_l_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, then randomized traffic
// checked against a behavioural model. Perf counters checked when
// STALL_PERF_EN is defined.
module tb_hazard_ctrl;

  localparam int unsigned MDU_CYC = 4;
  localparam int unsigned N_RAND  = 3000;

  localparam logic [9:0] ALL_A  = 10'b00_00_00_00_00;
  localparam logic [9:0] ALL_F  = 10'b01_01_01_01_01;
  localparam logic [9:0] LU     = 10'b10_10_01_00_00;
  localparam logic [9:0] MD     = 10'b10_10_10_01_00;
  localparam logic [9:0] DS     = 10'b10_10_10_10_01;
  localparam logic [9:0] IS_    = 10'b10_01_00_00_00;
  localparam logic [9:0] RD_IS  = 10'b10_01_01_00_00;
  localparam logic [9:0] RD_NOW = 10'b00_01_01_00_00;
  localparam logic [9:0] RP_REL = 10'b00_01_00_00_00;

  logic        clk = 1'b0;
  logic        reset, i_stall, d_stall, memreadE, mdu_startE, redirectE;
  logic [4:0]  ra1D, ra2D, dstE;
  logic [63:0] redirect_pcE;
  logic [1:0]  FWrite, DWrite, EWrite, MWrite, WWrite;
  logic        pc_redirect, mdu_busy;
  logic [63:0] pc_target;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_i, stall_cnt_d, stall_cnt_mdu, stall_cnt_lu;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_CYCLES(MDU_CYC), .PERF_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_stall      (i_stall),
    .d_stall      (d_stall),
    .ra1D         (ra1D),
    .ra2D         (ra2D),
    .dstE         (dstE),
    .memreadE     (memreadE),
    .mdu_startE   (mdu_startE),
    .redirectE    (redirectE),
    .redirect_pcE (redirect_pcE),
    .FWrite       (FWrite),
    .DWrite       (DWrite),
    .EWrite       (EWrite),
    .MWrite       (MWrite),
    .WWrite       (WWrite),
    .pc_redirect  (pc_redirect),
    .pc_target    (pc_target),
    .mdu_busy     (mdu_busy)
`ifdef STALL_PERF_EN
    ,
    .stall_cnt_i   (stall_cnt_i),
    .stall_cnt_d   (stall_cnt_d),
    .stall_cnt_mdu (stall_cnt_mdu),
    .stall_cnt_lu  (stall_cnt_lu)
`endif
  );

  typedef struct {
    logic        rst, is, ds;
    logic [4:0]  ra1, ra2, dst;
    logic        mr, ms, rd;
    logic [63:0] rpc;
    logic [9:0]  ectl;
    logic        epr, ebusy, chkpc;
    logic [63:0] epc;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: MDU remaining-hold count and pending redirect.
  bit          m_busy = 0;
  int          m_left = 0;
  bit          m_pend = 0;
  logic [63:0] m_pc   = '0;

  task automatic add(input logic rst, is, ds, input logic [4:0] ra1, ra2, dst,
                     input logic mr, ms, rd, input logic [63:0] rpc,
                     input logic [9:0] ectl, input logic epr, ebusy, chkpc,
                     input logic [63:0] epc);
    vec_t v;
    v.rst = rst; v.is = is; v.ds = ds; v.ra1 = ra1; v.ra2 = ra2; v.dst = dst;
    v.mr = mr; v.ms = ms; v.rd = rd; v.rpc = rpc; v.ectl = ectl; v.epr = epr;
    v.ebusy = ebusy; v.chkpc = chkpc; v.epc = epc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; i_stall = v.is; d_stall = v.ds; ra1D = v.ra1; ra2D = v.ra2;
    dstE = v.dst; memreadE = v.mr; mdu_startE = v.ms; redirectE = v.rd;
    redirect_pcE = v.rpc;
  endtask

  // Expected outputs from the rules, given the model state and inputs.
  function automatic void model_out(input vec_t v, output logic [9:0] ctl,
                                    output logic pr, output logic [63:0] pc,
                                    output logic busy);
    bit hold = m_busy && (m_left > 0);
    bit lu   = v.mr && (v.dst != 0) && (v.dst == v.ra1 || v.dst == v.ra2);
    logic [1:0] f = 2'b00, d = 2'b00, e = 2'b00, m = 2'b00, w = 2'b00;
    pr = 0; pc = '0; busy = m_busy;
    if (v.ds) begin
      f = 2'b10; d = 2'b10; e = 2'b10; m = 2'b10; w = 2'b01;
    end else if (hold) begin
      f = 2'b10; d = 2'b10; e = 2'b10; m = 2'b01;
    end else if (lu) begin
      f = 2'b10; d = 2'b10; e = 2'b01;
    end else if (v.rd || m_pend) begin
      f = v.is ? 2'b10 : 2'b00; d = 2'b01; e = v.rd ? 2'b01 : 2'b00;
    end else if (v.is) begin
      f = 2'b10; d = 2'b01;
    end
    if (!v.ds && !hold) begin
      if (v.rd && !v.is) begin pr = 1; pc = v.rpc; end
      else if (!v.rd && m_pend && !v.is) begin pr = 1; pc = m_pc; end
    end
    ctl = {f, d, e, m, w};
    if (v.rst) begin
      ctl = ALL_F; pr = 0; pc = '0; busy = 0;
    end
  endfunction

  function automatic void model_step(input vec_t v);
    bit hold = m_busy && (m_left > 0);
    bit was_idle = !m_busy && !m_pend;
    if (v.rst) begin
      m_busy = 0; m_left = 0; m_pend = 0; m_pc = '0;
      return;
    end
    if (m_busy && !v.ds) begin
      if (m_left > 0) m_left--;
      else m_busy = 0;
    end
    if (!v.ds && !hold) begin
      if (v.rd) begin
        if (v.is) begin m_pend = 1; m_pc = v.rpc; end
        else m_pend = 0;
      end else if (m_pend && !v.is) begin
        m_pend = 0;
      end
    end
    if (was_idle && v.ms) begin
      m_busy = 1; m_left = MDU_CYC - 1; m_pend = 0;
    end
  endfunction

  // One cycle: drive at negedge, compare #1 later, advance model at posedge.
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    logic [9:0]  ectl;
    logic        epr, ebusy;
    logic [63:0] epc;
    bit          chkpc;
    @(negedge clk);
    drive(v);
    #1;
    if (use_tbl) begin
      ectl = v.ectl; epr = v.epr; ebusy = v.ebusy; epc = v.epc; chkpc = v.chkpc;
    end else begin
      model_out(v, ectl, epr, epc, ebusy);
      chkpc = epr || v.rst;
    end
    chk({tag, " ctl"}, 64'({FWrite, DWrite, EWrite, MWrite, WWrite}), 64'(ectl));
    chk({tag, " pc_redirect"}, 64'(pc_redirect), 64'(epr));
    chk({tag, " mdu_busy"}, 64'(mdu_busy), 64'(ebusy));
    if (chkpc) chk({tag, " pc_target"}, pc_target, epc);
    @(posedge clk);
    model_step(v);
  endtask

  initial begin
    vec_t v;
    drive('{default: '0});
    // reset, load-use, x0
    add(1,0,0, 0,0,0,0, 0,0,0,         ALL_F, 0,0, 1,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);
    add(0,0,0, 5,0,5,1, 0,0,0,         LU,    0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);
    add(0,0,0, 0,0,0,1, 0,0,0,         ALL_A, 0,0, 0,0);
    add(0,0,0, 0,5,5,1, 0,0,0,         LU,    0,0, 0,0);
    // MDU op
    add(0,0,0, 0,0,0,0, 1,0,0,         ALL_A, 0,0, 0,0);
    for (int i = 0; i < 3; i++) add(0,0,0, 0,0,0,0, 0,0,0, MD, 0,1, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,1, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);
    // MDU op with 2-cycle d_stall mid-op
    add(0,0,0, 0,0,0,0, 1,0,0,         ALL_A, 0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         MD,    0,1, 0,0);
    add(0,0,1, 0,0,0,0, 0,0,0,         DS,    0,1, 0,0);
    add(0,0,1, 0,0,0,0, 0,0,0,         DS,    0,1, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         MD,    0,1, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         MD,    0,1, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,1, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);
    // d_stall coincident with MDU expiry
    add(0,0,0, 0,0,0,0, 1,0,0,         ALL_A, 0,0, 0,0);
    for (int i = 0; i < 3; i++) add(0,0,0, 0,0,0,0, 0,0,0, MD, 0,1, 0,0);
    add(0,0,1, 0,0,0,0, 0,0,0,         DS,    0,1, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,1, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);
    // redirect under i-fetch miss
    add(0,1,0, 0,0,0,0, 0,1,64'h8000_0100, RD_IS, 0,0, 0,0);
    for (int i = 0; i < 3; i++) add(0,1,0, 0,0,0,0, 0,0,0, IS_, 0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         RP_REL,0,0, 1,64'h8000_0100);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);
    // immediate redirect, plain i_stall, redirect ignored under d_stall
    add(0,0,0, 0,0,0,0, 0,1,64'h1234,  RD_NOW,1,0, 1,64'h1234);
    add(0,1,0, 0,0,0,0, 0,0,0,         IS_,   0,0, 0,0);
    add(0,1,1, 0,0,0,0, 0,1,64'h55,    DS,    0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);
    // pending redirect overwritten
    add(0,1,0, 0,0,0,0, 0,1,64'hA0,    RD_IS, 0,0, 0,0);
    add(0,1,0, 0,0,0,0, 0,1,64'hB0,    RD_IS, 0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         RP_REL,1,0, 1,64'hB0);
    // reset mid-MDU
    add(0,0,0, 0,0,0,0, 1,0,0,         ALL_A, 0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         MD,    0,1, 0,0);
    add(1,0,0, 0,0,0,0, 0,0,0,         ALL_F, 0,0, 1,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);
    // reset mid-pending
    add(0,1,0, 0,0,0,0, 0,1,64'hC0,    RD_IS, 0,0, 0,0);
    add(1,1,0, 0,0,0,0, 0,0,0,         ALL_F, 0,0, 1,0);
    add(0,0,0, 0,0,0,0, 0,0,0,         ALL_A, 0,0, 0,0);

    // Row 31 expects pc_redirect=1 after the pending miss resolves.
    tbl[31].epr = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, $sformatf("row%0d", i));

`ifdef STALL_PERF_EN
    v = '{default: '0};
    v.rst = 1; step(v, 1'b0, "perf_rst");
    v.rst = 0; v.is = 1;
    for (int i = 0; i < 3; i++) step(v, 1'b0, "perf_is");
    v.is = 0; v.mr = 1; v.dst = 7; v.ra1 = 7;
    for (int i = 0; i < 2; i++) step(v, 1'b0, "perf_lu");
    v = '{default: '0};
    step(v, 1'b0, "perf_idle");
    chk("stall_cnt_i", 64'(stall_cnt_i), 64'd3);
    chk("stall_cnt_lu", 64'(stall_cnt_lu), 64'd2);
    chk("stall_cnt_d", 64'(stall_cnt_d), 64'd0);
    chk("stall_cnt_mdu", 64'(stall_cnt_mdu), 64'd0);
`endif

    // Randomized traffic against the model.
    v = '{default: '0};
    v.rst = 1;
    step(v, 1'b0, "rnd_rst");
    for (int unsigned n = 0; n < N_RAND; n++) begin
      v.rst = ($urandom_range(63) == 0);
      v.is  = ($urandom_range(9) < 3);
      v.ds  = ($urandom_range(19) < 3);
      v.ra1 = 5'($urandom_range(3));
      v.ra2 = 5'($urandom_range(3));
      v.dst = 5'($urandom_range(3));
      v.mr  = ($urandom_range(9) < 3);
      v.ms  = ($urandom_range(19) == 0);
      v.rd  = !v.ms && ($urandom_range(9) == 0);
      v.rpc = {32'($urandom), 32'($urandom)};
      step(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
